dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 = pipeline MEM stage, port 1 = loader/DMA port.

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 has priority, port 1 is guaranteed service and may lock.
// Define DMEM_ARB_STATS_EN to add the CNT0/CNT1/CONFLICTS statistics outputs.
module dmem_arbiter #(
  parameter int DWL     = 32,
  parameter int AWL     = 9,
  parameter int MAXWAIT = 4
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           REQ0,
  input  logic           WE0,
  input  logic [AWL-1:0] ADDR0,
  input  logic [DWL-1:0] WD0,
  output logic           GNT0,
  output logic           STALL0,
  input  logic           REQ1,
  input  logic           LOCK1,
  input  logic           WE1,
  input  logic [AWL-1:0] ADDR1,
  input  logic [DWL-1:0] WD1,
  output logic           GNT1,
  output logic [DWL-1:0] RDATA,
  output logic           RVALID0,
  output logic           RVALID1,
  output logic [AWL-1:0] DMA,
  output logic [DWL-1:0] DMWD,
  output logic           DMWE,
  input  logic [DWL-1:0] DMRD
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]    CNT0,
  output logic [31:0]    CNT1,
  output logic [15:0]    CONFLICTS
`endif
);

  typedef enum logic [0:0] {
    OPEN    = 1'b0,
    LOCKED1 = 1'b1
  } state_t;

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  state_t         state_r;
  state_t         state_nxt_s;
  logic [3:0]     wait_r;
  logic [3:0]     wait_nxt_s;
  logic           gnt0_s;
  logic           gnt1_s;
  logic           rd0_s;
  logic           rd1_s;
  logic [DWL-1:0] rdata_r;
  logic           rvalid0_r;
  logic           rvalid1_r;

  // Grant decision and lock state transitions.
  always_comb begin
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      OPEN: begin
        if (REQ1 && (!REQ0 || (wait_r == MAXW))) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = REQ0;
        end
        if (gnt1_s && LOCK1) begin
          state_nxt_s = LOCKED1;
        end else begin
          state_nxt_s = OPEN;
        end
      end
      LOCKED1: begin
        gnt1_s = REQ1;
        if (LOCK1) begin
          state_nxt_s = LOCKED1;
        end else begin
          state_nxt_s = OPEN;
        end
      end
      default: begin
        state_nxt_s = OPEN;
      end
    endcase
  end

  // Starvation counter for port 1, saturating at MAXWAIT.
  always_comb begin
    wait_nxt_s = wait_r;
    if (gnt1_s || !REQ1) begin
      wait_nxt_s = 4'd0;
    end else if (wait_r == MAXW) begin
      wait_nxt_s = wait_r;
    end else begin
      wait_nxt_s = wait_r + 4'd1;
    end
  end

  // Memory-side mux; write enable is suppressed while reset is asserted.
  always_comb begin
    DMA  = ADDR0;
    DMWD = WD0;
    if (gnt1_s) begin
      DMA  = ADDR1;
      DMWD = WD1;
    end else begin
      DMA  = ADDR0;
      DMWD = WD0;
    end
    DMWE = RSTN & ((gnt0_s & WE0) | (gnt1_s & WE1));
  end

  assign GNT0    = gnt0_s;
  assign GNT1    = gnt1_s;
  assign STALL0  = REQ0 & ~gnt0_s;
  assign rd0_s   = gnt0_s & ~WE0;
  assign rd1_s   = gnt1_s & ~WE1;
  assign RDATA   = rdata_r;
  assign RVALID0 = rvalid0_r;
  assign RVALID1 = rvalid1_r;

  // State, wait counter and registered read return.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_r   <= OPEN;
      wait_r    <= 4'd0;
      rdata_r   <= '0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      wait_r    <= wait_nxt_s;
      rvalid0_r <= rd0_s;
      rvalid1_r <= rd1_s;
      if (rd0_s || rd1_s) begin
        rdata_r <= DMRD;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cnt0_r;
  logic [31:0] cnt1_r;
  logic [15:0] conf_r;

  // Grant counters wrap; the conflict counter saturates.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt0_r <= 32'd0;
      cnt1_r <= 32'd0;
      conf_r <= 16'd0;
    end else begin
      cnt0_r <= cnt0_r + {31'd0, gnt0_s};
      cnt1_r <= cnt1_r + {31'd0, gnt1_s};
      if (REQ0 && REQ1 && (conf_r != 16'hFFFF)) begin
        conf_r <= conf_r + 16'd1;
      end else begin
        conf_r <= conf_r;
      end
    end
  end

  assign CNT0      = cnt0_r;
  assign CNT1      = cnt1_r;
  assign CONFLICTS = conf_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then randomized requesters against a reference model.
module tb_dmem_arbiter;

  localparam int MAXWAIT = 4;

  logic        CLK = 1'b0;
  logic        RSTN, REQ0, WE0, REQ1, LOCK1, WE1;
  logic [8:0]  ADDR0, ADDR1;
  logic [31:0] WD0, WD1;
  logic        GNT0, STALL0, GNT1, RVALID0, RVALID1, DMWE;
  logic [31:0] RDATA, DMWD, DMRD;
  logic [8:0]  DMA;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] CNT0, CNT1;
  logic [15:0] CONFLICTS;
`endif

  dmem_arbiter #(.DWL(32), .AWL(9), .MAXWAIT(MAXWAIT)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WD0(WD0), .GNT0(GNT0), .STALL0(STALL0),
    .REQ1(REQ1), .LOCK1(LOCK1), .WE1(WE1), .ADDR1(ADDR1), .WD1(WD1), .GNT1(GNT1),
    .RDATA(RDATA), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .DMA(DMA), .DMWD(DMWD), .DMWE(DMWE), .DMRD(DMRD)
`ifdef DMEM_ARB_STATS_EN
    , .CNT0(CNT0), .CNT1(CNT1), .CONFLICTS(CONFLICTS)
`endif
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  assign DMRD = mem[DMA];

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  bit      m_locked = 1'b0;
  int      m_wait   = 0;
  longint  m_cnt0 = 0, m_cnt1 = 0, m_conf = 0;
  bit      last_g0, last_g1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: inputs are already applied just after the falling edge.
  task automatic step();
    bit eg0, eg1, ewe;
    logic [8:0]  ea, da;
    logic [31:0] ed, dd;
    logic        dwe;
    #1;
    if (m_locked) begin
      eg1 = REQ1;
      eg0 = 1'b0;
    end else begin
      eg1 = REQ1 && (!REQ0 || m_wait == MAXWAIT);
      eg0 = REQ0 && !eg1;
    end
    ea  = eg1 ? ADDR1 : ADDR0;
    ed  = eg1 ? WD1 : WD0;
    ewe = RSTN && ((eg0 && WE0) || (eg1 && WE1));
    chk("gnt0", GNT0, eg0);
    chk("gnt1", GNT1, eg1);
    chk("stall0", STALL0, REQ0 && !eg0);
    chk("dmwe", DMWE, ewe);
    chk("dma", DMA, ea);
    chk("dmwd", DMWD, ed);
`ifdef DMEM_ARB_STATS_EN
    chk("cnt0", CNT0, 32'(m_cnt0));
    chk("cnt1", CNT1, 32'(m_cnt1));
    chk("conflicts", CONFLICTS, 32'(m_conf));
`endif
    if (RSTN && eg0 && !WE0) exp_q.push_back({1'b0, ref_mem[ADDR0]});
    if (RSTN && eg1 && !WE1) exp_q.push_back({1'b1, ref_mem[ADDR1]});
    last_g0 = eg0;
    last_g1 = eg1;
    dwe = DMWE; da = DMA; dd = DMWD;
    @(posedge CLK);
    if (dwe) mem[da] = dd;
    if (ewe) ref_mem[ea] = ed;
    if (!RSTN) begin
      m_locked = 1'b0; m_wait = 0; m_cnt0 = 0; m_cnt1 = 0; m_conf = 0;
    end else begin
      m_locked = m_locked ? LOCK1 : (eg1 && LOCK1);
      if (eg1 || !REQ1) m_wait = 0;
      else if (m_wait < MAXWAIT) m_wait = m_wait + 1;
      m_cnt0 = (m_cnt0 + (eg0 ? 1 : 0)) % 64'h1_0000_0000;
      m_cnt1 = (m_cnt1 + (eg1 ? 1 : 0)) % 64'h1_0000_0000;
      if (REQ0 && REQ1 && m_conf < 65535) m_conf = m_conf + 1;
    end
    @(negedge CLK);
  endtask

  // Monitor: every read return must match the oldest expected entry, one cycle after grant.
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge CLK);
      #2;
      if (RVALID0 || RVALID1) begin
        if (exp_q.size() == 0) begin
          chk("stray_rvalid", {30'd0, RVALID1, RVALID0}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_port", {30'd0, RVALID1, RVALID0}, e[32] ? 32'd2 : 32'd1);
          chk("rdata", RDATA, e[31:0]);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missing_rvalid", {31'd0, e[32]}, 32'hFFFF_FFFF);
      end
    end
  end

  initial begin
    logic [31:0] keep5;
    bit p0, p1;
    int bad;
    RSTN = 1'b0; REQ0 = 1'b0; WE0 = 1'b0; ADDR0 = 9'd0; WD0 = 32'd0;
    REQ1 = 1'b0; LOCK1 = 1'b0; WE1 = 1'b0; ADDR1 = 9'd0; WD1 = 32'd0;
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    keep5 = mem[5];
    @(posedge CLK);
    @(negedge CLK);

    // Reset with a pending port-0 write
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'd5; WD0 = 32'hFFFF_0000;
    step(); step();
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_rvalid0", RVALID0, 1'b0);
    chk("rst_rvalid1", RVALID1, 1'b0);
    chk("rst_mem5", mem[5], keep5);
    RSTN = 1'b1; REQ0 = 1'b0; WE0 = 1'b0;

    // Contention: port 1 wins on the fifth cycle
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'd20; WD0 = 32'h1111_2222;
    REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 9'd21; WD1 = 32'h3333_4444;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_gnt1", GNT1, (i == 4) ? 32'd1 : 32'd0);
      chk("t3_stall0", STALL0, (i == 4) ? 32'd1 : 32'd0);
      step();
    end
`ifdef DMEM_ARB_STATS_EN
    chk("t6_cnt0", CNT0, 32'd4);
    chk("t6_cnt1", CNT1, 32'd1);
    chk("t6_conflicts", CONFLICTS, 32'd5);
`endif
    REQ1 = 1'b0;
    step();
    REQ0 = 1'b0;

    // Port 0 alone: write then read back
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'd5; WD0 = 32'hDEAD_BEEF;
    step();
    WE0 = 1'b0;
    step();
    chk("t2_rdata", RDATA, 32'hDEAD_BEEF);
    chk("t2_rvalid0", RVALID0, 1'b1);
    REQ0 = 1'b0;
    step();

    // Locked burst writing 10..15 while port 0 waits
    REQ1 = 1'b1; LOCK1 = 1'b1; WE1 = 1'b1; ADDR1 = 9'd10; WD1 = $urandom;
    step();
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 9'd3;
    for (int a = 11; a <= 15; a++) begin
      ADDR1 = 9'(a); WD1 = $urandom;
      if (a == 15) LOCK1 = 1'b0;
      #1;
      chk("t4_gnt0", GNT0, 1'b0);
      chk("t4_stall0", STALL0, 1'b1);
      step();
    end
    REQ1 = 1'b0;
    #1;
    chk("t4_resume", GNT0, 1'b1);
    step();
    REQ0 = 1'b0;
    for (int a = 10; a <= 15; a++) begin
      REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 9'(a);
      step();
    end
    REQ1 = 1'b0;
    step();

    // Reset in the third locked cycle drops the lock
    REQ1 = 1'b1; LOCK1 = 1'b1; WE1 = 1'b0; ADDR1 = 9'd30;
    step();
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 9'd7;
    step();
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    #1;
    chk("t5_gnt0", GNT0, 1'b1);
    chk("t5_gnt1", GNT1, 1'b0);
    step();
    REQ0 = 1'b0; REQ1 = 1'b0; LOCK1 = 1'b0;
    step();

    // Randomized requesters that hold their request until granted
    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!p0) begin
        REQ0 = ($urandom % 3 != 0);
        WE0 = $urandom % 2; ADDR0 = 9'($urandom % 32); WD0 = $urandom;
        p0 = REQ0;
      end
      if (!p1) begin
        REQ1 = ($urandom % 2 == 0);
        WE1 = $urandom % 2; ADDR1 = 9'($urandom % 32); WD1 = $urandom;
        p1 = REQ1;
      end
      LOCK1 = ($urandom % 3 == 0);
      RSTN = ($urandom % 150 != 0);
      step();
      if (last_g0) p0 = 1'b0;
      if (last_g1) p1 = 1'b0;
    end
    RSTN = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; LOCK1 = 1'b0;
    step(); step();

    chk("queue_drained", exp_q.size(), 32'd0);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (mem[i] !== ref_mem[i]) bad++;
    end
    chk("mem_image", bad, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
